// File: rtl/ultrasonido_pkg.sv
// rtl/ultrasonido_pkg.sv - shared types, widths and defaults for the ultrasonic driver
package ultrasonido_pkg;

  localparam int unsigned ECHO_W        = 22;
  localparam int unsigned CYCLES_PER_CM = 2900;

  localparam int unsigned TRIG_CYCLES_DEF   = 500;
  localparam int unsigned ECHO_TIMEOUT_DEF  = 1_500_000;
  localparam int unsigned THRESH_CYCLES_DEF = 20 * CYCLES_PER_CM;
  localparam int unsigned PERIOD_CYCLES_DEF = 3_000_000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_ECHO,
    ST_MEASURE,
    ST_HOLDOFF
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous sensor pins
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ultrasonido_driver.sv
// rtl/ultrasonido_driver.sv - periodic trigger, echo width measurement and presence flag
module ultrasonido_driver
  import ultrasonido_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES   = TRIG_CYCLES_DEF,
  parameter int unsigned ECHO_TIMEOUT  = ECHO_TIMEOUT_DEF,
  parameter int unsigned THRESH_CYCLES = THRESH_CYCLES_DEF,
  parameter int unsigned PERIOD_CYCLES = PERIOD_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              echo_in,
  output logic              trig_out,
  output logic [ECHO_W-1:0] echo_cycles,
  output logic              presencia,
  output logic              timeout,
  output logic              dato_valido
);

  localparam logic [ECHO_W-1:0] ONE          = ECHO_W'(1);
  localparam logic [ECHO_W-1:0] TRIG_LAST    = ECHO_W'(TRIG_CYCLES - 1);
  localparam logic [ECHO_W-1:0] TIMEOUT_MAX  = ECHO_W'(ECHO_TIMEOUT);
  localparam logic [ECHO_W-1:0] TIMEOUT_LAST = ECHO_W'(ECHO_TIMEOUT - 1);
  localparam logic [ECHO_W-1:0] THRESH       = ECHO_W'(THRESH_CYCLES);
  localparam logic [ECHO_W-1:0] PERIOD_LAST  = ECHO_W'(PERIOD_CYCLES - 1);

  logic echo_s;

  sync_2ff u_echo_sync (
    .clk   (clk),
    .reset (reset),
    .d     (echo_in),
    .q     (echo_s)
  );

  state_t            state, state_nxt;
  logic [ECHO_W-1:0] cnt, cnt_nxt;
  logic [ECHO_W-1:0] per_cnt, per_nxt;
  logic              trig_nxt;
  logic [ECHO_W-1:0] cycles_nxt;
  logic              pres_nxt, tout_nxt, valid_nxt;
  logic              start, pub_timeout, pub_echo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      per_cnt     <= '0;
      trig_out    <= 1'b0;
      echo_cycles <= '0;
      presencia   <= 1'b0;
      timeout     <= 1'b0;
      dato_valido <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      per_cnt     <= per_nxt;
      trig_out    <= trig_nxt;
      echo_cycles <= cycles_nxt;
      presencia   <= pres_nxt;
      timeout     <= tout_nxt;
      dato_valido <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    per_nxt     = (per_cnt < PERIOD_LAST) ? per_cnt + ONE : per_cnt;
    trig_nxt    = trig_out;
    cycles_nxt  = echo_cycles;
    pres_nxt    = presencia;
    tout_nxt    = timeout;
    valid_nxt   = 1'b0;
    start       = 1'b0;
    pub_timeout = 1'b0;
    pub_echo    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (enable) start = 1'b1;
      end
      ST_TRIG: begin
        if (cnt == TRIG_LAST) begin
          state_nxt = ST_WAIT_ECHO;
          trig_nxt  = 1'b0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      ST_WAIT_ECHO: begin
        // an echo already high here is taken as the echo start
        if (echo_s) begin
          state_nxt = ST_MEASURE;
          cnt_nxt   = ONE;
        end else if (cnt == TIMEOUT_LAST) begin
          pub_timeout = 1'b1;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      ST_MEASURE: begin
        if (!echo_s)                pub_echo    = 1'b1;
        else if (cnt >= TIMEOUT_MAX) pub_timeout = 1'b1;
        else                        cnt_nxt     = cnt + ONE;
      end
      ST_HOLDOFF: begin
        // a stuck echo must clear before the sensor is re-triggered
        if (per_cnt >= PERIOD_LAST && !echo_s) begin
          if (enable) start = 1'b1;
          else        state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (start) begin
      state_nxt = ST_TRIG;
      trig_nxt  = 1'b1;
      cnt_nxt   = '0;
      per_nxt   = '0;
    end

    if (pub_timeout) begin
      state_nxt  = ST_HOLDOFF;
      cycles_nxt = TIMEOUT_MAX;
      pres_nxt   = 1'b0;
      tout_nxt   = 1'b1;
      valid_nxt  = 1'b1;
    end

    if (pub_echo) begin
      state_nxt  = ST_HOLDOFF;
      cycles_nxt = cnt;
      pres_nxt   = (cnt < THRESH);
      tout_nxt   = 1'b0;
      valid_nxt  = 1'b1;
    end
  end

endmodule

// File: tb/tb_ultrasonido_driver.sv
// tb/tb_ultrasonido_driver.sv - directed self-checking bench for ultrasonido_driver
module tb_ultrasonido_driver;
  import ultrasonido_pkg::*;

  localparam int unsigned TRIG = 4;
  localparam int unsigned TOUT = 100;
  localparam int unsigned THR  = 40;
  localparam int unsigned PER  = 200;

  logic              clk = 1'b0;
  logic              reset, enable, echo_in;
  logic              trig_out;
  logic [ECHO_W-1:0] echo_cycles;
  logic              presencia, timeout, dato_valido;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_rise   = 0;

  ultrasonido_driver #(
    .TRIG_CYCLES   (TRIG),
    .ECHO_TIMEOUT  (TOUT),
    .THRESH_CYCLES (THR),
    .PERIOD_CYCLES (PER)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .echo_in     (echo_in),
    .trig_out    (trig_out),
    .echo_cycles (echo_cycles),
    .presencia   (presencia),
    .timeout     (timeout),
    .dato_valido (dato_valido)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_rise(input string tag, input int limit);
    int n = 0;
    while (trig_out !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    chk(tag, trig_out, 1);
  endtask

  task automatic wait_fall(input int limit);
    int n = 0;
    while (trig_out !== 1'b0 && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic check_period(input string tag);
    chk(tag, cyc - t_rise, PER);
    t_rise = cyc;
  endtask

  // echo of `width` synchronous cycles starting `delay` cycles after the trigger falls
  task automatic do_echo(input string tag, input int delay, input int width, input int drop_at,
                         input int exp_cycles, input logic exp_pres);
    wait_fall(20);
    repeat (delay) tick();
    echo_in = 1'b1;
    for (int i = 0; i < width; i++) begin
      if (i == drop_at) enable = 1'b0;
      tick();
    end
    echo_in = 1'b0;
    tick();
    tick();
    chk({tag, "_dv_early"}, dato_valido, 0);
    tick();
    chk({tag, "_dv"}, dato_valido, 1);
    chk({tag, "_cycles"}, echo_cycles, exp_cycles);
    chk({tag, "_presencia"}, presencia, exp_pres);
    chk({tag, "_timeout"}, timeout, 0);
    tick();
    chk({tag, "_dv_late"}, dato_valido, 0);
  endtask

  initial begin
    int w;
    int n;
    int dv_at;
    int trig_hi;
    logic [ECHO_W-1:0] cyc_s;
    logic to_s, pr_s;

    reset   = 1'b0;
    enable  = 1'b0;
    echo_in = 1'b0;
    tick();
    tick();
    chk("rst_trig", trig_out, 0);
    chk("rst_cycles", echo_cycles, 0);
    chk("rst_presencia", presencia, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_dv", dato_valido, 0);
    reset = 1'b1;
    tick();
    tick();
    chk("idle_no_trig", trig_out, 0);

    // near echo
    enable = 1'b1;
    tick();
    chk("trig_rise", trig_out, 1);
    t_rise = cyc;
    w = 0;
    while (trig_out === 1'b1 && w < 20) begin
      tick();
      w++;
    end
    chk("trig_width", w, TRIG);
    do_echo("near", 10, 25, -1, 25, 1'b1);

    // threshold boundary
    wait_rise("far_rise", 300);
    check_period("far_period");
    do_echo("far40", 10, 40, -1, 40, 1'b0);
    wait_rise("edge_rise", 300);
    check_period("edge_period");
    do_echo("edge39", 10, 39, -1, 39, 1'b1);

    // no echo
    wait_rise("noecho_rise", 300);
    check_period("noecho_period");
    wait_fall(20);
    n = 0;
    while (dato_valido !== 1'b1 && n < 150) begin
      tick();
      n++;
    end
    chk("noecho_latency", n, TOUT);
    chk("noecho_timeout", timeout, 1);
    chk("noecho_cycles", echo_cycles, TOUT);
    chk("noecho_presencia", presencia, 0);

    // stuck echo
    wait_rise("stuck_rise", 300);
    check_period("stuck_period");
    wait_fall(20);
    repeat (10) tick();
    echo_in = 1'b1;
    dv_at   = 0;
    trig_hi = 0;
    cyc_s   = '0;
    to_s    = 1'b0;
    pr_s    = 1'b1;
    for (int j = 1; j <= 300; j++) begin
      tick();
      if (dato_valido === 1'b1 && dv_at == 0) begin
        dv_at = j;
        cyc_s = echo_cycles;
        to_s  = timeout;
        pr_s  = presencia;
      end
      if (trig_out === 1'b1) trig_hi++;
    end
    chk("stuck_dv_at", dv_at, 103);
    chk("stuck_cycles", cyc_s, TOUT);
    chk("stuck_timeout", to_s, 1);
    chk("stuck_presencia", pr_s, 0);
    chk("stuck_no_trig", trig_hi, 0);
    echo_in = 1'b0;
    tick();
    tick();
    chk("stuck_trig_held", trig_out, 0);
    tick();
    chk("stuck_trig_release", trig_out, 1);

    // asynchronous reset in the middle of TRIG
    #2;
    reset = 1'b0;
    #1;
    chk("areset_trig", trig_out, 0);
    chk("areset_cycles", echo_cycles, 0);
    chk("areset_presencia", presencia, 0);
    chk("areset_timeout", timeout, 0);
    enable = 1'b0;
    tick();
    reset = 1'b1;
    trig_hi = 0;
    for (int j = 0; j < 500; j++) begin
      tick();
      if (trig_out === 1'b1) trig_hi++;
    end
    chk("disabled_no_trig", trig_hi, 0);

    // enable dropped during MEASURE
    enable = 1'b1;
    tick();
    chk("drop_trig_rise", trig_out, 1);
    do_echo("drop", 10, 30, 15, 30, 1'b1);
    trig_hi = 0;
    for (int j = 0; j < 500; j++) begin
      tick();
      if (trig_out === 1'b1) trig_hi++;
    end
    chk("drop_no_trig", trig_hi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
